status_monitor: RTL and testbench
=================================

STATUS_MONITOR -- requirements
Module: status_monitor

Interface
REQ-001 SHALL have parameter PC_W, default 32, width of the monitored PC.
REQ-002 SHALL have parameter PASS_PC, default 32'h000005f0, pass-loop address.
REQ-003 SHALL have parameter FAIL_PC, default 32'h000005dc, fail-loop address; PASS_PC != FAIL_PC is required.
REQ-004 SHALL have parameter HIT_COUNT, default 2, range 1..255, matching retirements needed for a verdict.
REQ-005 SHALL have parameter TIMEOUT, default 650, cycle budget; 0 disables the timeout.
REQ-006 SHALL have parameter STALL_LIMIT, default 64, max consecutive cycles without pc_valid; 0 disables.
REQ-007 SHALL have parameter CNT_W, default 32, counter width.
REQ-008 SHALL have ports: clk in 1 (clock, all logic on rising edge); rst in 1 (synchronous, active-high reset).
REQ-009 SHALL have ports: start in 1 (arm pulse); clear in 1 (return to IDLE); pc_valid in 1 (qualifies pc); pc in PC_W (PC of the retired/decoded instruction).
REQ-010 SHALL have ports: busy out 1 (state RUN); done out 1 (one-cycle pulse on verdict entry); verdict out 2 (00 none, 01 pass, 10 fail, 11 timeout/stall).
REQ-011 SHALL have ports: stalled out 1 (verdict 11 caused by stall); cycle_count out CNT_W (cycles spent in RUN); retire_count out CNT_W (pc_valid beats in RUN); verdict_pc out PC_W (last valid pc at verdict).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, PASS, FAIL, TIMEOUT; encoding is free.
REQ-013 IDLE -> RUN SHALL occur on start=1; cycle_count, retire_count, hit counters and stall counter SHALL clear on that edge.
REQ-014 In RUN, cycle_count SHALL increment by 1 each cycle and saturate at all-ones.
REQ-015 In RUN, retire_count SHALL increment on each pc_valid=1 and saturate at all-ones.
REQ-016 pass_hits SHALL increment on pc_valid && pc==PASS_PC; fail_hits on pc_valid && pc==FAIL_PC; both 8-bit, saturating; non-matching pcs SHALL not reset them.
REQ-017 RUN -> PASS SHALL occur on the edge where pass_hits would reach HIT_COUNT; RUN -> FAIL likewise for fail_hits.
REQ-018 RUN -> TIMEOUT SHALL occur when TIMEOUT!=0 and cycle_count==TIMEOUT-1 with no pass/fail hit completing on that edge.
REQ-019 RUN -> TIMEOUT with stalled=1 SHALL occur when STALL_LIMIT!=0 and the stall counter reaches STALL_LIMIT; the stall counter SHALL clear on pc_valid=1.
REQ-020 Priority on simultaneous events in one cycle SHALL be: PASS/FAIL hit > timeout > stall.
REQ-021 done SHALL pulse high for exactly the first cycle after entering PASS/FAIL/TIMEOUT (registered, one cycle after the triggering input edge).
REQ-022 verdict, stalled, verdict_pc, cycle_count and retire_count SHALL hold (sticky) in PASS/FAIL/TIMEOUT.
REQ-023 verdict_pc SHALL capture pc on each pc_valid in RUN and freeze on verdict.
REQ-024 start SHALL be ignored outside IDLE; clear SHALL force IDLE from any state, zero all outputs next cycle, and win over start in the same cycle.
REQ-025 busy SHALL be 1 exactly while in RUN.

Reset
REQ-026 On rst=1 at a rising edge, state SHALL go to IDLE and busy, done, verdict, stalled, cycle_count, retire_count, verdict_pc and the internal counters SHALL be 0.
REQ-027 rst SHALL override start and clear; reset mid-RUN SHALL abandon the run with no done pulse.

Verification
REQ-028 Pass: start, then pc stream 0x0..0x5ec, 0x5f0, 0x5f4, 0x5f0, all valid -> verdict=01, done one cycle, verdict_pc=0x5f0.
REQ-029 Fail: start, then pc=0x5dc valid twice with other pcs between -> verdict=10 on the second hit; a single hit alone -> stays RUN.
REQ-030 Timeout: TIMEOUT=10, start, no matching pc -> verdict=11, stalled=0, cycle_count=10; coincident pass hit on the last cycle -> verdict=01.
REQ-031 Stall: STALL_LIMIT=4, start, pc_valid held 0 -> verdict=11, stalled=1 after 4 RUN cycles; a pc_valid on cycle 3 restarts the count.
REQ-032 Control: start while in PASS is ignored; clear+start in one cycle -> IDLE; rst asserted mid-RUN -> all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/status_monitor.sv
// -----------------------------------------------------------------------------
// status_monitor
//
// Watches the PC stream of a core under test and produces a verdict when the
// program parks in its pass or fail loop. A run is armed by start. It ends in
// PASS or FAIL after HIT_COUNT retirements at the matching address. It ends in
// TIMEOUT when the cycle budget runs out or when pc_valid stays low for too long.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst          : synchronous active-high reset
//   start        : arm pulse, only honoured in IDLE
//   clear        : return to IDLE and zero every output, wins over start
//   pc_valid     : qualifies pc
//   pc           : PC of the retired instruction
//   busy         : high while a run is in progress
//   done         : one-cycle pulse on the first cycle of a verdict
//   verdict      : 00 none, 01 pass, 10 fail, 11 timeout/stall
//   stalled      : verdict 11 was caused by the stall watchdog
//   cycle_count  : cycles spent in RUN (saturating)
//   retire_count : pc_valid beats seen in RUN (saturating)
//   verdict_pc   : last valid pc, frozen at the verdict
// -----------------------------------------------------------------------------
module status_monitor #(
   parameter int              PC_W        = 32,
   parameter logic [PC_W-1:0] PASS_PC     = PC_W'(32'h000005f0),
   parameter logic [PC_W-1:0] FAIL_PC     = PC_W'(32'h000005dc),
   parameter int              HIT_COUNT   = 2,
   parameter int              TIMEOUT     = 650,
   parameter int              STALL_LIMIT = 64,
   parameter int              CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             clear,
   input  logic             pc_valid,
   input  logic [PC_W-1:0]  pc,
   output logic             busy,
   output logic             done,
   output logic [1:0]       verdict,
   output logic             stalled,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retire_count,
   output logic [PC_W-1:0]  verdict_pc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TIMEOUT
   } state_t;

   // Trigger values are "one before the limit": a verdict fires on the edge
   // where the counter would reach the limit, not one cycle later.
   localparam logic [7:0]       HIT_LAST   = 8'(HIT_COUNT - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cycle_cnt, retire_cnt, stall_cnt;
   logic [7:0]       pass_hits, fail_hits;
   logic [PC_W-1:0]  last_pc;
   logic             stall_flag, done_r;

   logic pass_match, fail_match;
   logic pass_hit, fail_hit, timeout_hit, stall_hit;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [7:0] sat_inc_hit(input logic [7:0] v);
      return (&v) ? v : v + 8'd1;
   endfunction

   assign pass_match  = pc_valid && (pc == PASS_PC);
   assign fail_match  = pc_valid && (pc == FAIL_PC);
   assign pass_hit    = pass_match && (pass_hits >= HIT_LAST);
   assign fail_hit    = fail_match && (fail_hits >= HIT_LAST);
   assign timeout_hit = (TIMEOUT != 0) && (cycle_cnt == TO_LAST);
   assign stall_hit   = (STALL_LIMIT != 0) && !pc_valid && (stall_cnt >= STALL_LAST);

   // State register plus the run bookkeeping that lives alongside it
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state      <= S_IDLE;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         stall_cnt  <= '0;
         pass_hits  <= '0;
         fail_hits  <= '0;
         last_pc    <= '0;
         stall_flag <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state  <= state_nxt;
         // Only RUN can leave towards a verdict; clear was handled above.
         done_r <= (state == S_RUN) && (state_nxt != S_RUN);
         if (state == S_IDLE && start) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
            pass_hits  <= '0;
            fail_hits  <= '0;
            last_pc    <= '0;
            stall_flag <= 1'b0;
         end else if (state == S_RUN) begin
            cycle_cnt <= sat_inc_cnt(cycle_cnt);
            if (pc_valid) begin
               retire_cnt <= sat_inc_cnt(retire_cnt);
               last_pc    <= pc;
               stall_cnt  <= '0;
            end else begin
               stall_cnt  <= sat_inc_cnt(stall_cnt);
            end
            if (pass_match) pass_hits <= sat_inc_hit(pass_hits);
            if (fail_match) fail_hits <= sat_inc_hit(fail_hits);
            // A TIMEOUT entry not explained by the cycle budget came from the stall watchdog.
            stall_flag <= (state_nxt == S_TIMEOUT) && !timeout_hit;
         end
      end
   end

   // Next-state logic; order of the RUN tests encodes hit > timeout > stall
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_RUN;
         S_RUN: begin
            if (pass_hit)         state_nxt = S_PASS;
            else if (fail_hit)    state_nxt = S_FAIL;
            else if (timeout_hit) state_nxt = S_TIMEOUT;
            else if (stall_hit)   state_nxt = S_TIMEOUT;
         end
         default: state_nxt = state;
      endcase
      if (clear) state_nxt = S_IDLE;
   end

   // Outputs
   always_comb begin
      busy    = (state == S_RUN);
      verdict = 2'b00;
      case (state)
         S_PASS:    verdict = 2'b01;
         S_FAIL:    verdict = 2'b10;
         S_TIMEOUT: verdict = 2'b11;
         default:   verdict = 2'b00;
      endcase
      done         = done_r;
      stalled      = stall_flag;
      cycle_count  = cycle_cnt;
      retire_count = retire_cnt;
      verdict_pc   = last_pc;
   end

endmodule

// File: tb/tb_status_monitor.sv
module tb_status_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b0, start = 1'b0, clear = 1'b0, pc_valid = 1'b0;
   logic [31:0] pc = '0;

   // a: default parameters; b: TIMEOUT=10, STALL_LIMIT=4. Inputs are shared.
   logic        busy_a, done_a, stalled_a, busy_b, done_b, stalled_b;
   logic [1:0]  verdict_a, verdict_b;
   logic [31:0] cyc_a, ret_a, vpc_a, cyc_b, ret_b, vpc_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   status_monitor u_dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear), .pc_valid(pc_valid), .pc(pc),
      .busy(busy_a), .done(done_a), .verdict(verdict_a), .stalled(stalled_a),
      .cycle_count(cyc_a), .retire_count(ret_a), .verdict_pc(vpc_a)
   );

   status_monitor #(.TIMEOUT(10), .STALL_LIMIT(4)) u_small (
      .clk(clk), .rst(rst), .start(start), .clear(clear), .pc_valid(pc_valid), .pc(pc),
      .busy(busy_b), .done(done_b), .verdict(verdict_b), .stalled(stalled_b),
      .cycle_count(cyc_b), .retire_count(ret_b), .verdict_pc(vpc_b)
   );

   typedef struct {
      logic        rst, start, clear, pv;
      logic [31:0] pc;
      logic        busy, done;
      logic [1:0]  verdict;
      logic        stalled;
      logic [31:0] cyc, ret, vpc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic s, logic c, logic v, logic [31:0] p,
                               logic b, logic d, logic [1:0] vd, logic st,
                               logic [31:0] cy, logic [31:0] rt, logic [31:0] vp);
      vec_t x;
      x.rst = r; x.start = s; x.clear = c; x.pv = v; x.pc = p;
      x.busy = b; x.done = d; x.verdict = vd; x.stalled = st;
      x.cyc = cy; x.ret = rt; x.vpc = vp;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Apply inputs, then sample one time unit after the rising edge.
   task automatic tick(input logic r, input logic s, input logic c, input logic v,
                       input logic [31:0] p);
      rst = r; start = s; clear = c; pc_valid = v; pc = p;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b(input string tag, input logic b, input logic d, input logic [1:0] vd,
                        input logic st, input logic [31:0] cy, input logic [31:0] rt,
                        input logic [31:0] vp);
      chk({tag, ".busy"}, 32'(busy_b), 32'(b));
      chk({tag, ".done"}, 32'(done_b), 32'(d));
      chk({tag, ".verdict"}, 32'(verdict_b), 32'(vd));
      chk({tag, ".stalled"}, 32'(stalled_b), 32'(st));
      chk({tag, ".cycle_count"}, cyc_b, cy);
      chk({tag, ".retire_count"}, ret_b, rt);
      chk({tag, ".verdict_pc"}, vpc_b, vp);
   endtask

   initial begin
      // ---- table: reset, fail verdict, control, timeout on u_small ----
      tbl.push_back(mk(1,0,0,0,32'h0,     0,0,2'b00,0, 0,0,32'h0));    // reset
      tbl.push_back(mk(0,1,0,0,32'h0,     1,0,2'b00,0, 0,0,32'h0));    // arm
      tbl.push_back(mk(0,0,0,1,32'h5dc,   1,0,2'b00,0, 1,1,32'h5dc));  // single fail hit stays RUN
      tbl.push_back(mk(0,0,0,1,32'h100,   1,0,2'b00,0, 2,2,32'h100));
      tbl.push_back(mk(0,0,0,0,32'h0,     1,0,2'b00,0, 3,2,32'h100));
      tbl.push_back(mk(0,0,0,1,32'h5dc,   0,1,2'b10,0, 4,3,32'h5dc));  // second hit -> FAIL
      tbl.push_back(mk(0,0,0,1,32'h5f0,   0,0,2'b10,0, 4,3,32'h5dc));  // sticky, done drops
      tbl.push_back(mk(0,1,0,0,32'h0,     0,0,2'b10,0, 4,3,32'h5dc));  // start ignored
      tbl.push_back(mk(0,0,1,0,32'h0,     0,0,2'b00,0, 0,0,32'h0));    // clear
      tbl.push_back(mk(0,1,0,0,32'h0,     1,0,2'b00,0, 0,0,32'h0));    // re-arm
      for (int j = 0; j < 9; j++)
         tbl.push_back(mk(0,0,0,1,32'h20, 1,0,2'b00,0, 32'(j+1),32'(j+1),32'h20));
      tbl.push_back(mk(0,0,0,1,32'h24,    0,1,2'b11,0, 10,10,32'h24)); // timeout
      tbl.push_back(mk(0,0,0,1,32'h28,    0,0,2'b11,0, 10,10,32'h24)); // sticky

      for (int i = 0; i < tbl.size(); i++) begin
         tick(tbl[i].rst, tbl[i].start, tbl[i].clear, tbl[i].pv, tbl[i].pc);
         chk_b($sformatf("vec%0d", i), tbl[i].busy, tbl[i].done, tbl[i].verdict,
               tbl[i].stalled, tbl[i].cyc, tbl[i].ret, tbl[i].vpc);
      end

      // ---- pass hit coincides with the last budget cycle: pass wins ----
      tick(0,0,1,0,32'h0);
      tick(0,1,0,0,32'h0);
      tick(0,0,0,1,32'h5f0);
      for (int j = 0; j < 8; j++) tick(0,0,0,1,32'h40);
      chk("coinc.busy_before", 32'(busy_b), 32'd1);
      tick(0,0,0,1,32'h5f0);
      chk_b("coinc", 0, 1, 2'b01, 0, 10, 10, 32'h5f0);

      // ---- stall with pc_valid held low ----
      tick(0,0,1,0,32'h0);
      tick(0,1,0,0,32'h0);
      for (int j = 0; j < 3; j++) tick(0,0,0,0,32'h0);
      chk("stall.busy_at3", 32'(busy_b), 32'd1);
      tick(0,0,0,0,32'h0);
      chk_b("stall", 0, 1, 2'b11, 1, 4, 0, 32'h0);

      // ---- valid beat on RUN cycle 3 restarts the stall count ----
      tick(0,0,1,0,32'h0);
      tick(0,1,0,0,32'h0);
      tick(0,0,0,0,32'h0);
      tick(0,0,0,0,32'h0);
      tick(0,0,0,1,32'h80);
      for (int j = 0; j < 3; j++) tick(0,0,0,0,32'h0);
      chk("restall.busy", 32'(busy_b), 32'd1);
      tick(0,0,0,0,32'h0);
      chk_b("restall", 0, 1, 2'b11, 1, 7, 1, 32'h80);

      // ---- full pass program on the default-parameter instance ----
      tick(0,0,1,0,32'h0);
      tick(0,1,0,0,32'h0);
      for (int a = 0; a <= 32'h5ec; a += 4) tick(0,0,0,1,32'(a));
      tick(0,0,0,1,32'h5f0);
      tick(0,0,0,1,32'h5f4);
      chk("pass.busy_after_one_hit", 32'(busy_a), 32'd1);
      tick(0,0,0,1,32'h5f0);
      chk("pass.verdict", 32'(verdict_a), 32'd1);
      chk("pass.done", 32'(done_a), 32'd1);
      chk("pass.busy", 32'(busy_a), 32'd0);
      chk("pass.verdict_pc", vpc_a, 32'h5f0);
      chk("pass.retire_count", ret_a, 32'd383);
      chk("pass.cycle_count", cyc_a, 32'd383);
      tick(0,1,0,1,32'h5dc);                      // start in PASS is ignored
      chk("pass.done_one_cycle", 32'(done_a), 32'd0);
      chk("pass.sticky_verdict", 32'(verdict_a), 32'd1);
      chk("pass.start_ignored", 32'(busy_a), 32'd0);
      chk("pass.sticky_pc", vpc_a, 32'h5f0);

      // ---- clear and start together go to IDLE ----
      tick(0,1,1,0,32'h0);
      chk("clrstart.busy", 32'(busy_a), 32'd0);
      chk("clrstart.verdict", 32'(verdict_a), 32'd0);
      chk("clrstart.cycle_count", cyc_a, 32'd0);
      chk("clrstart.verdict_pc", vpc_a, 32'h0);

      // ---- reset mid-RUN abandons the run silently ----
      tick(0,1,0,0,32'h0);
      tick(0,0,0,1,32'h5f0);
      tick(0,0,0,1,32'h10);
      chk("rstrun.busy_before", 32'(busy_a), 32'd1);
      tick(1,1,1,1,32'h5f0);
      chk("rstrun.busy", 32'(busy_a), 32'd0);
      chk("rstrun.done", 32'(done_a), 32'd0);
      chk("rstrun.verdict", 32'(verdict_a), 32'd0);
      chk("rstrun.cycle_count", cyc_a, 32'd0);
      chk("rstrun.retire_count", ret_a, 32'd0);
      chk("rstrun.verdict_pc", vpc_a, 32'h0);
      tick(0,0,0,0,32'h0);
      chk("rstrun.no_late_done", 32'(done_a), 32'd0);
      chk("rstrun.idle", 32'(busy_a), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
